mcif_rd_arb: RTL and testbench

Sequential round-robin read arbiter for the memory controller interface (MCIF). It shares one read-command channel and one read-data return path between NUM_REQ client engines (feature, weight, bias, instruction fetch). A grant is held for a whole burst, from command handshake to the last returned beat, and then passes to the next requester in cyclic order. It sits between the client read ports and the MCIF command/data channel.

---
 rtl/mcif_rd_arb_pkg.sv | 17 +
 rtl/mcif_rr_pick.sv | 29 ++
 rtl/mcif_rd_arb.sv | 134 +++++++++++++
 tb/tb_mcif_rd_arb.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcif_rd_arb_pkg.sv
// Shared types and default widths for the MCIF read arbiter.
// State encodings match the legacy CNN defines header.
package mcif_rd_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 32;
    localparam int LEN_W_DEF   = 8;
    localparam int DATA_W_DEF  = 256;
    localparam int ID_W        = 3;

    typedef enum logic [1:0] {
        MCIF_ARB_IDLE = 2'd0,
        MCIF_ARB_CMD  = 2'd1,
        MCIF_ARB_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mcif_rr_pick.sv
// Round-robin winner select: first asserted request after last_id.
// Purely combinational; all selects use constant indices.
module mcif_rr_pick
    import mcif_rd_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    always_comb begin
        winner = '0;
        any    = |req;
        for (int l = 0; l < NUM_REQ; l++) begin
            if (last_id == ID_W'(l)) begin
                // Walk farthest-first so the nearest hit wins.
                for (int k = NUM_REQ; k >= 1; k--) begin
                    if (req[(l + k) % NUM_REQ]) begin
                        winner = ID_W'((l + k) % NUM_REQ);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mcif_rd_arb.sv
// Round-robin read arbiter sharing one MCIF command/data channel.
// A grant covers a whole burst, command handshake to last beat.
module mcif_rd_arb
    import mcif_rd_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [ADDR_W-1:0]         cmd_addr,
    output logic [LEN_W-1:0]          cmd_len,
    input  logic                      mem_rd_valid,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_last,
    output logic [ID_W-1:0]           arb_id,
    output logic                      busy,
    output logic                      err
);

    arb_state_e        state;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   pick_last;
    logic [ID_W-1:0]   winner;
    logic              any_req;
    logic [LEN_W:0]    beat_cnt;
    logic              beat_in_data;
    logic              last_beat;
    logic              cmd_fire;
    logic              grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;

    // On the last beat last_id is still stale, so rotate from arb_id.
    assign pick_last = (state == MCIF_ARB_DATA) ? arb_id : last_id;

    mcif_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req_valid),
        .last_id (pick_last),
        .winner  (winner),
        .any     (any_req)
    );

    assign cmd_fire     = cmd_valid && cmd_ready;
    assign beat_in_data = (state == MCIF_ARB_DATA) && mem_rd_valid;
    assign last_beat    = beat_in_data && (beat_cnt == {1'b0, cmd_len});
    assign grant        = any_req
                        && ((state == MCIF_ARB_IDLE) || last_beat);

    assign rd_data = mem_rd_data;
    assign rd_last = last_beat;
    assign busy    = (state != MCIF_ARB_IDLE);

    always_comb begin
        req_ready = '0;
        rd_valid  = '0;
        if (cmd_fire) begin
            req_ready = NUM_REQ'(1) << arb_id;
        end
        if (beat_in_data) begin
            rd_valid = NUM_REQ'(1) << arb_id;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MCIF_ARB_IDLE;
            last_id   <= ID_W'(NUM_REQ - 1);
            arb_id    <= '0;
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            if (mem_rd_valid && (state != MCIF_ARB_DATA)) begin
                err <= 1'b1;
            end
            unique case (state)
                MCIF_ARB_IDLE: begin
                end
                MCIF_ARB_CMD: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= MCIF_ARB_DATA;
                    end
                end
                MCIF_ARB_DATA: begin
                    if (mem_rd_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            last_id <= arb_id;
                            state   <= MCIF_ARB_IDLE;
                        end
                    end
                end
                default: state <= MCIF_ARB_IDLE;
            endcase
            // A new grant overrides the IDLE fall-back above.
            if (grant) begin
                arb_id    <= winner;
                cmd_addr  <= sel_addr;
                cmd_len   <= sel_len;
                cmd_valid <= 1'b1;
                state     <= MCIF_ARB_CMD;
            end
        end
    end

endmodule

// File: tb/tb_mcif_rd_arb.sv
// Bench for mcif_rd_arb: vector table, directed corners, random traffic
// checked against a burst-level reference model.
module tb_mcif_rd_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int DW = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    req_ready;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic [LW-1:0]   cmd_len;
    logic            mem_rd_valid;
    logic [DW-1:0]   mem_rd_data;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;
    logic            rd_last;
    logic [2:0]      arb_id;
    logic            busy;
    logic            err;

    mcif_rd_arb dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_ready    (req_ready),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .arb_id       (arb_id),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the channel and how many beats remain.
    int          m_owner;
    bit          m_issued;
    int          m_left;
    int          m_last;
    int          m_arb;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    bit          m_err;

    logic [N-1:0] exp_rr;
    logic [N-1:0] obs_rr;
    logic [N-1:0] obs_rv;
    int           rr_pulses;
    int           last_seen;

    typedef struct {
        logic [N-1:0]  rq;
        logic          cr;
        logic          mv;
        logic          cv;
        logic [N-1:0]  rr;
        logic [N-1:0]  rv;
        logic          lst;
        logic          bsy;
        logic [2:0]    arb;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit in_data();
        return (m_owner >= 0) && m_issued;
    endfunction

    task automatic m_reset();
        m_owner  = -1;
        m_issued = 0;
        m_left   = 0;
        m_last   = N - 1;
        m_arb    = 0;
        m_addr   = '0;
        m_len    = '0;
        m_err    = 0;
    endtask

    task automatic m_grant(input int w);
        m_owner  = w;
        m_arb    = w;
        m_issued = 0;
        m_addr   = req_addr[w*AW +: AW];
        m_len    = req_len[w*LW +: LW];
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [LW-1:0] l);
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]  = l;
    endtask

    task automatic step(input logic [N-1:0] rq, input bit cr, input bit mv);
        logic [N-1:0]  erv;
        logic          elast;
        logic [DW-1:0] d;
        int            w;
        @(negedge clk);
        d            = {8{$urandom}};
        req_valid    = rq;
        cmd_ready    = cr;
        mem_rd_valid = mv;
        mem_rd_data  = d;
        #1;
        exp_rr = (m_owner >= 0 && !m_issued && cr) ? (N'(1) << m_owner) : '0;
        erv    = (in_data() && mv) ? (N'(1) << m_owner) : '0;
        elast  = in_data() && mv && (m_left == 1);
        obs_rr = req_ready;
        obs_rv = rd_valid;
        if (req_ready != '0) rr_pulses++;
        if (rd_last) last_seen++;
        chk("cmd_valid", DW'(cmd_valid), DW'(m_owner >= 0 && !m_issued));
        chk("req_ready", DW'(req_ready), DW'(exp_rr));
        chk("rd_valid", DW'(rd_valid), DW'(erv));
        chk("rd_last", DW'(rd_last), DW'(elast));
        chk("busy", DW'(busy), DW'(m_owner >= 0));
        chk("arb_id", DW'(arb_id), DW'(m_arb));
        chk("cmd_addr", DW'(cmd_addr), DW'(m_addr));
        chk("cmd_len", DW'(cmd_len), DW'(m_len));
        chk("err", DW'(err), DW'(m_err));
        chk("rd_data", rd_data, d);
        // Advance the model to the state after the coming edge.
        if (m_owner < 0) begin
            if (mv) m_err = 1;
            w = rr_pick(rq, m_last);
            if (w >= 0) m_grant(w);
        end else if (!m_issued) begin
            if (mv) m_err = 1;
            if (cr) begin
                m_issued = 1;
                m_left   = int'(m_len) + 1;
            end
        end else if (mv) begin
            m_left--;
            if (m_left == 0) begin
                m_last  = m_owner;
                m_owner = -1;
                w = rr_pick(rq, m_last);
                if (w >= 0) m_grant(w);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid    = '0;
        cmd_ready    = 1'b0;
        mem_rd_valid = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (m_owner >= 0 && k < 600) begin
            step('0, 1'b1, in_data());
            k++;
        end
        step('0, 1'b1, 1'b0);
        chk("drain_idle", DW'(busy), DW'(0));
    endtask

    initial begin
        logic [N-1:0] pend;
        int order[$];
        int k;
        int rv2_hits;

        rst          = 1'b1;
        req_valid    = '0;
        req_addr     = '0;
        req_len      = '0;
        cmd_ready    = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        rr_pulses    = 0;
        last_seen    = 0;
        m_reset();

        // Reset state.
        do_reset();
        step('0, 1'b0, 1'b0);

        // Single request: req0 addr 0x1000 len 3, with one idle gap.
        set_req(0, 32'h1000, 8'd3);
        tbl[0] = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000,
                   1'b0, 1'b0, 3'd0, 32'h0, 8'd0};
        tbl[1] = '{4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000,
                   1'b0, 1'b1, 3'd0, 32'h1000, 8'd3};
        tbl[2] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001,
                   1'b0, 1'b1, 3'd0, 32'h1000, 8'd3};
        tbl[3] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001,
                   1'b0, 1'b1, 3'd0, 32'h1000, 8'd3};
        tbl[4] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000,
                   1'b0, 1'b1, 3'd0, 32'h1000, 8'd3};
        tbl[5] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001,
                   1'b0, 1'b1, 3'd0, 32'h1000, 8'd3};
        tbl[6] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001,
                   1'b1, 1'b1, 3'd0, 32'h1000, 8'd3};
        tbl[7] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000,
                   1'b0, 1'b0, 3'd0, 32'h1000, 8'd3};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rq, tbl[i].cr, tbl[i].mv);
            chk($sformatf("tbl%0d_cv", i), DW'(cmd_valid), DW'(tbl[i].cv));
            chk($sformatf("tbl%0d_rr", i), DW'(req_ready), DW'(tbl[i].rr));
            chk($sformatf("tbl%0d_rv", i), DW'(rd_valid), DW'(tbl[i].rv));
            chk($sformatf("tbl%0d_last", i), DW'(rd_last), DW'(tbl[i].lst));
            chk($sformatf("tbl%0d_busy", i), DW'(busy), DW'(tbl[i].bsy));
            chk($sformatf("tbl%0d_arb", i), DW'(arb_id), DW'(tbl[i].arb));
            chk($sformatf("tbl%0d_addr", i), DW'(cmd_addr), DW'(tbl[i].addr));
            chk($sformatf("tbl%0d_len", i), DW'(cmd_len), DW'(tbl[i].len));
        end

        // All four requesting continuously with len 0.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, AW'(32'h2000 + i * 32'h100), 8'd0);
        k = 0;
        while (order.size() < 5 && k < 60) begin
            step(4'hF, 1'b1, in_data());
            for (int j = 0; j < N; j++) if (obs_rr[j]) order.push_back(j);
            k++;
        end
        chk("rr_count", DW'(order.size()), DW'(5));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_order%0d", i),
                DW'(i < order.size() ? order[i] : -1), DW'(i % 4));
        end
        drain();

        // req2 arrives during req0's 8-beat burst.
        set_req(0, 32'h3000, 8'd7);
        set_req(2, 32'h3200, 8'd1);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        rv2_hits  = 0;
        last_seen = 0;
        for (int b = 0; b < 8; b++) begin
            step(4'b0100, 1'b1, 1'b1);
            if (obs_rv[2]) rv2_hits++;
        end
        chk("mid_rv2_during_req0", DW'(rv2_hits), DW'(0));
        chk("mid_req0_last", DW'(last_seen), DW'(1));
        step(4'b0100, 1'b1, 1'b0);
        chk("mid_grant2", DW'(obs_rr), DW'(4'b0100));
        chk("mid_arb2", DW'(arb_id), DW'(2));
        drain();

        // cmd_ready held low for 5 cycles.
        set_req(1, 32'hABCD0040, 8'd2);
        rr_pulses = 0;
        step(4'b0010, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(4'b0010, 1'b0, 1'b0);
            chk("hold_cv", DW'(cmd_valid), DW'(1));
            chk("hold_addr", DW'(cmd_addr), DW'(32'hABCD0040));
            chk("hold_len", DW'(cmd_len), DW'(2));
        end
        step(4'b0010, 1'b1, 1'b0);
        drain();
        chk("hold_rr_pulses", DW'(rr_pulses), DW'(1));

        // Maximum burst length: 256 beats, one rd_last at the end.
        set_req(3, 32'h4000, 8'hFF);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        last_seen = 0;
        for (int b = 0; b < 255; b++) step('0, 1'b1, 1'b1);
        chk("len255_no_early_last", DW'(last_seen), DW'(0));
        step('0, 1'b1, 1'b1);
        chk("len255_last", DW'(last_seen), DW'(1));
        drain();

        // Random traffic.
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    set_req(i, $urandom & ~32'h1F,
                            ($urandom_range(0, 9) == 0)
                                ? LW'($urandom_range(4, 20))
                                : LW'($urandom_range(0, 3)));
                end
            end
            step(pend, $urandom_range(0, 3) != 0,
                 in_data() && ($urandom_range(0, 3) != 0));
            pend &= ~exp_rr;
        end
        k = 0;
        while (pend != '0 && k < 2000) begin
            step(pend, 1'b1, in_data());
            pend &= ~exp_rr;
            k++;
        end
        drain();

        // Stray beat in IDLE sets a sticky err.
        step('0, 1'b0, 1'b1);
        chk("stray_rv", DW'(obs_rv), DW'(0));
        step('0, 1'b0, 1'b0);
        chk("stray_err", DW'(err), DW'(1));
        repeat (3) step('0, 1'b0, 1'b0);
        chk("stray_err_held", DW'(err), DW'(1));

        // Reset after 2 of 4 beats; previous winner was requester 1.
        set_req(1, 32'h5100, 8'd0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step('0, 1'b1, 1'b1);
        set_req(0, 32'h5000, 8'd3);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step('0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b1);
        @(negedge clk);
        rst          = 1'b1;
        mem_rd_valid = 1'b1;
        #1;
        chk("rst_cmd_valid", DW'(cmd_valid), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_rd_valid", DW'(rd_valid), DW'(0));
        chk("rst_rd_last", DW'(rd_last), DW'(0));
        chk("rst_req_ready", DW'(req_ready), DW'(0));
        chk("rst_cmd_addr", DW'(cmd_addr), DW'(0));
        chk("rst_cmd_len", DW'(cmd_len), DW'(0));
        chk("rst_arb_id", DW'(arb_id), DW'(0));
        chk("rst_err", DW'(err), DW'(0));
        m_reset();
        @(negedge clk);
        rst          = 1'b0;
        mem_rd_valid = 1'b0;
        step('0, 1'b0, 1'b1);
        step(4'b1001, 1'b1, 1'b0);
        step(4'b1001, 1'b1, 1'b0);
        chk("post_rst_grant0", DW'(obs_rr), DW'(4'b0001));
        step(4'b1000, 1'b1, in_data());
        k = 0;
        while (m_owner >= 0 && k < 20) begin
            step(4'b1000 & ~exp_rr, 1'b1, in_data());
            k++;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
